// File: rtl/ping_pong_scheduler.sv
// ping_pong_scheduler: tracks two ping-pong banks through EMPTY/FILL/FULL/DRAIN,
// gates each stream's TREADY per bank and issues in-order drain requests to the DMA.
module ping_pong_scheduler #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ENABLE,
    input  logic [31:0]      PACKETS_PER_GROUP,
    input  logic             MON0_TVALID,
    input  logic             MON0_TREADY,
    input  logic             MON0_TLAST,
    input  logic             MON1_TVALID,
    input  logic             MON1_TREADY,
    input  logic             MON1_TLAST,
    output logic [1:0]       BANK_ALLOW,
    output logic             REQ_VALID,
    input  logic             REQ_READY,
    output logic             REQ_BANK,
    output logic [31:0]      REQ_PACKETS,
    input  logic             DONE_VALID,
    input  logic             DONE_BANK,
    output logic [CNT_W-1:0] GROUP_COUNT,
    output logic [CNT_W-1:0] STALL_COUNT,
    output logic             ERR_SPURIOUS,
    output logic             ERR_PROTOCOL
);
    typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} bank_state_t;
    bank_state_t      r_state [2];
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [31:0]      r_pkt_cnt;
    logic [31:0]      r_ppg [2];
    logic [1:0]       r_allow;
    logic [CNT_W-1:0] r_group;
    logic [CNT_W-1:0] r_stall;
    logic             r_err_spur;
    logic             r_err_prot;
    logic [1:0]       w_hs;
    logic [1:0]       w_last_beat;
    logic             w_pkt;
    logic             w_final;
    logic             w_start;
    logic             w_req_fire;
    logic             w_done_ok;
    logic             w_wr_busy;
    logic [31:0]      w_ppg_in;

    assign w_hs        = {MON1_TVALID & MON1_TREADY, MON0_TVALID & MON0_TREADY};
    assign w_last_beat = {MON1_TLAST, MON0_TLAST};
    // only the write bank can ever be in FILL, so its stream alone advances the count
    assign w_pkt       = (r_state[r_wr_bank] == FILL) & r_allow[r_wr_bank] & w_hs[r_wr_bank] & w_last_beat[r_wr_bank];
    assign w_final     = w_pkt & (r_pkt_cnt + 32'd1 == r_ppg[r_wr_bank]);
    assign w_start     = ENABLE & (r_state[r_wr_bank] == EMPTY);
    assign w_req_fire  = REQ_VALID & REQ_READY;
    assign w_done_ok   = DONE_VALID & (r_state[DONE_BANK] == DRAIN);
    assign w_wr_busy   = (r_state[r_wr_bank] == FULL) | (r_state[r_wr_bank] == DRAIN);
    assign w_ppg_in    = (PACKETS_PER_GROUP == '0) ? 32'd1 : PACKETS_PER_GROUP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state[0] <= EMPTY;
            r_state[1] <= EMPTY;
            r_ppg[0]   <= '0;
            r_ppg[1]   <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_pkt_cnt  <= '0;
            r_allow    <= '0;
            r_group    <= '0;
            r_stall    <= '0;
            r_err_spur <= 1'b0;
            r_err_prot <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_start && r_wr_bank == 1'(b)) begin
                    r_state[b] <= FILL;
                    r_ppg[b]   <= w_ppg_in;
                end else if (w_final && r_wr_bank == 1'(b))
                    r_state[b] <= FULL;
                else if (w_req_fire && r_rd_bank == 1'(b))
                    r_state[b] <= DRAIN;
                else if (w_done_ok && DONE_BANK == 1'(b))
                    r_state[b] <= EMPTY;
                r_allow[b] <= (r_state[b] == FILL);
            end
            r_pkt_cnt  <= (w_start || w_final) ? '0 : r_pkt_cnt + 32'(w_pkt);
            r_wr_bank  <= r_wr_bank ^ w_final;
            r_rd_bank  <= r_rd_bank ^ w_req_fire;
            r_group    <= r_group + CNT_W'(w_final);
            r_stall    <= r_stall + CNT_W'(ENABLE & w_wr_busy);
            r_err_spur <= r_err_spur | (DONE_VALID & ~w_done_ok);
            r_err_prot <= r_err_prot | (|(w_hs & ~r_allow));
        end
    end

    // request outputs come straight from state registers: no path from REQ_READY
    assign BANK_ALLOW   = r_allow;
    assign REQ_VALID    = (r_state[r_rd_bank] == FULL);
    assign REQ_BANK     = r_rd_bank;
    assign REQ_PACKETS  = r_ppg[r_rd_bank];
    assign GROUP_COUNT  = r_group;
    assign STALL_COUNT  = r_stall;
    assign ERR_SPURIOUS = r_err_spur;
    assign ERR_PROTOCOL = r_err_prot;
endmodule

// File: tb/tb_ping_pong_scheduler.sv
// tb_ping_pong_scheduler: directed scenarios checked every cycle against a
// queue-based bank model, plus hand-computed literal expectations.
module tb_ping_pong_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ENABLE = 1'b0;
    logic [31:0] PACKETS_PER_GROUP = 32'd3;
    logic        MON0_TVALID = 1'b0, MON0_TREADY = 1'b0, MON0_TLAST = 1'b0;
    logic        MON1_TVALID = 1'b0, MON1_TREADY = 1'b0, MON1_TLAST = 1'b0;
    logic [1:0]  BANK_ALLOW;
    logic        REQ_VALID;
    logic        REQ_READY = 1'b0;
    logic        REQ_BANK;
    logic [31:0] REQ_PACKETS;
    logic        DONE_VALID = 1'b0;
    logic        DONE_BANK = 1'b0;
    logic [31:0] GROUP_COUNT;
    logic [31:0] STALL_COUNT;
    logic        ERR_SPURIOUS;
    logic        ERR_PROTOCOL;

    int n_chk = 0;
    int n_fail = 0;

    ping_pong_scheduler #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .ENABLE(ENABLE), .PACKETS_PER_GROUP(PACKETS_PER_GROUP),
        .MON0_TVALID(MON0_TVALID), .MON0_TREADY(MON0_TREADY), .MON0_TLAST(MON0_TLAST),
        .MON1_TVALID(MON1_TVALID), .MON1_TREADY(MON1_TREADY), .MON1_TLAST(MON1_TLAST),
        .BANK_ALLOW(BANK_ALLOW), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_BANK(REQ_BANK), .REQ_PACKETS(REQ_PACKETS), .DONE_VALID(DONE_VALID),
        .DONE_BANK(DONE_BANK), .GROUP_COUNT(GROUP_COUNT), .STALL_COUNT(STALL_COUNT),
        .ERR_SPURIOUS(ERR_SPURIOUS), .ERR_PROTOCOL(ERR_PROTOCOL)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: phase 0=empty 1=fill 2=full 3=drain; full banks wait in a FIFO in fill order
    int          m_ph [2];
    int          m_wr;
    logic [31:0] m_cnt;
    logic [31:0] m_ppg [2];
    bit          m_alw [2];
    int          m_q [$];
    logic [31:0] m_grp, m_stl;
    bit          m_errs, m_errp;
    bit          hs [2], lst [2], nalw [2];
    int          ow;
    bit          done_ok, pkt, fin, start;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph = '{0, 0}; m_wr = 0; m_cnt = 0; m_ppg = '{0, 0}; m_alw = '{0, 0};
            m_q.delete(); m_grp = 0; m_stl = 0; m_errs = 0; m_errp = 0;
        end else begin
            hs[0] = MON0_TVALID && MON0_TREADY; lst[0] = MON0_TLAST;
            hs[1] = MON1_TVALID && MON1_TREADY; lst[1] = MON1_TLAST;
            ow = m_wr;
            for (int b = 0; b < 2; b++) begin
                nalw[b] = (m_ph[b] == 1);
                if (hs[b] && !m_alw[b]) m_errp = 1;
            end
            if (ENABLE && m_ph[ow] >= 2) m_stl++;
            done_ok = DONE_VALID && m_ph[DONE_BANK] == 3;
            if (DONE_VALID && !done_ok) m_errs = 1;
            pkt   = m_ph[ow] == 1 && m_alw[ow] && hs[ow] && lst[ow];
            fin   = pkt && (m_cnt + 1 == m_ppg[ow]);
            start = ENABLE && m_ph[ow] == 0;
            if (done_ok) m_ph[DONE_BANK] = 0;
            if (m_q.size() > 0 && REQ_READY) begin
                m_ph[m_q[0]] = 3;
                void'(m_q.pop_front());
            end
            if (fin) begin
                m_ph[ow] = 2; m_q.push_back(ow); m_wr = 1 - ow; m_cnt = 0; m_grp++;
            end else if (pkt) m_cnt++;
            if (start) begin
                m_ph[ow] = 1; m_cnt = 0;
                m_ppg[ow] = (PACKETS_PER_GROUP == 0) ? 32'd1 : PACKETS_PER_GROUP;
            end
            m_alw = nalw;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("allow", BANK_ALLOW, {m_alw[1], m_alw[0]});
            chk("req_valid", REQ_VALID, m_q.size() > 0);
            if (m_q.size() > 0) begin
                chk("req_bank", REQ_BANK, m_q[0]);
                chk("req_packets", REQ_PACKETS, m_ppg[m_q[0]]);
            end
            chk("group_count", GROUP_COUNT, m_grp);
            chk("stall_count", STALL_COUNT, m_stl);
            chk("err_spurious", ERR_SPURIOUS, m_errs);
            chk("err_protocol", ERR_PROTOCOL, m_errp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_alw(input int b);
        int n = 0;
        while (!m_alw[b] && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_allow%0d: got timeout expected allow=1", b);
        end
    endtask

    task automatic pkt_on(input int b);
        wait_alw(b);
        if (b == 0) {MON0_TVALID, MON0_TREADY, MON0_TLAST} = 3'b111;
        else        {MON1_TVALID, MON1_TREADY, MON1_TLAST} = 3'b111;
        tick();
        {MON0_TVALID, MON0_TREADY, MON0_TLAST} = 3'b000;
        {MON1_TVALID, MON1_TREADY, MON1_TLAST} = 3'b000;
    endtask

    task automatic done_on(input logic b);
        DONE_VALID = 1'b1;
        DONE_BANK = b;
        tick();
        DONE_VALID = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick();
        chk("rst_allow", BANK_ALLOW, 2'b00);
        chk("rst_req_valid", REQ_VALID, 0);
        chk("rst_req_bank", REQ_BANK, 0);
        chk("rst_req_packets", REQ_PACKETS, 0);
        chk("rst_group", GROUP_COUNT, 0);
        chk("rst_stall", STALL_COUNT, 0);
        chk("rst_errs", {ERR_SPURIOUS, ERR_PROTOCOL}, 2'b00);
        reset = 1'b0;
        // 1: basic fill / request / done flow
        ENABLE = 1'b1; REQ_READY = 1'b1; PACKETS_PER_GROUP = 32'd3;
        repeat (3) pkt_on(0);
        chk("t1_req_valid", REQ_VALID, 1);
        chk("t1_req_bank", REQ_BANK, 0);
        chk("t1_req_packets", REQ_PACKETS, 3);
        chk("t1_group", GROUP_COUNT, 1);
        repeat (10) tick();
        done_on(1'b0);
        repeat (3) pkt_on(1);
        chk("t1_req_bank1", REQ_BANK, 1);
        chk("t1_req_packets1", REQ_PACKETS, 3);
        chk("t1_group2", GROUP_COUNT, 2);
        repeat (10) tick();
        done_on(1'b1);
        repeat (3) tick();
        // 2: DONE withheld, both banks busy, stall counting
        do_reset();
        PACKETS_PER_GROUP = 32'd2;
        repeat (2) pkt_on(0);
        repeat (2) pkt_on(1);
        repeat (5) tick();
        chk("t2_allow_blocked", BANK_ALLOW, 2'b00);
        chk("t2_stall5", STALL_COUNT, 5);
        chk("t2_group", GROUP_COUNT, 2);
        done_on(1'b0);
        chk("t2_allow_d1", BANK_ALLOW, 2'b00);
        tick();
        chk("t2_allow_d2", BANK_ALLOW, 2'b00);
        tick();
        chk("t2_allow_d3", BANK_ALLOW, 2'b01);
        chk("t2_stall6", STALL_COUNT, 6);
        // 3: request held under back-pressure, then in-order back-to-back
        REQ_READY = 1'b0;
        do_reset();
        repeat (2) pkt_on(0);
        repeat (2) pkt_on(1);
        for (int i = 0; i < 20; i++) begin
            chk("t3_hold_valid", REQ_VALID, 1);
            chk("t3_hold_bank", REQ_BANK, 0);
            tick();
        end
        REQ_READY = 1'b1;
        tick();
        chk("t3_b2b_valid", REQ_VALID, 1);
        chk("t3_b2b_bank", REQ_BANK, 1);
        tick();
        chk("t3_drop_valid", REQ_VALID, 0);
        REQ_READY = 1'b0;
        // 4: spurious DONE and protocol violation
        REQ_READY = 1'b1;
        do_reset();
        repeat (2) pkt_on(0);
        wait_alw(1);
        done_on(1'b1);
        chk("t4_err_spurious", ERR_SPURIOUS, 1);
        chk("t4_allow_kept", BANK_ALLOW, 2'b10);
        chk("t4_err_prot_clear", ERR_PROTOCOL, 0);
        repeat (2) pkt_on(1);
        tick();
        chk("t4_allow_off", BANK_ALLOW, 2'b00);
        {MON1_TVALID, MON1_TREADY, MON1_TLAST} = 3'b111;
        tick();
        {MON1_TVALID, MON1_TREADY, MON1_TLAST} = 3'b000;
        chk("t4_err_protocol", ERR_PROTOCOL, 1);
        chk("t4_group", GROUP_COUNT, 2);
        // 5: PPG=0 behaves as 1; mid-fill PPG change applies to the next group
        REQ_READY = 1'b0;
        PACKETS_PER_GROUP = 32'd0;
        do_reset();
        wait_alw(0);
        PACKETS_PER_GROUP = 32'd5;
        pkt_on(0);
        chk("t5_req_valid", REQ_VALID, 1);
        chk("t5_req_packets1", REQ_PACKETS, 1);
        repeat (2) pkt_on(1);
        PACKETS_PER_GROUP = 32'd2;
        repeat (2) pkt_on(1);
        chk("t5_group_4pk", GROUP_COUNT, 1);
        pkt_on(1);
        chk("t5_group_5pk", GROUP_COUNT, 2);
        chk("t5_req_bank0", REQ_BANK, 0);
        REQ_READY = 1'b1;
        tick();
        chk("t5_req_bank1", REQ_BANK, 1);
        chk("t5_req_packets5", REQ_PACKETS, 5);
        tick();
        chk("t5_req_drop", REQ_VALID, 0);
        done_on(1'b0);
        repeat (2) pkt_on(0);
        chk("t5_group3", GROUP_COUNT, 3);
        chk("t5_req_packets2", REQ_PACKETS, 2);
        chk("t5_req_bank_again", REQ_BANK, 0);
        // 6: asynchronous reset mid-fill
        PACKETS_PER_GROUP = 32'd4;
        do_reset();
        repeat (2) pkt_on(0);
        chk("t6_pre_allow", BANK_ALLOW, 2'b01);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_allow", BANK_ALLOW, 2'b00);
        chk("t6_async_req", REQ_VALID, 0);
        chk("t6_async_group", GROUP_COUNT, 0);
        tick();
        reset = 1'b0;
        repeat (2) pkt_on(0);
        chk("t6_restart_2pk", GROUP_COUNT, 0);
        repeat (2) pkt_on(0);
        chk("t6_restart_4pk", GROUP_COUNT, 1);
        chk("t6_req_packets", REQ_PACKETS, 4);
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
